fir_coeff_loader: RTL and testbench

Upstream coefficient sequencer for the FIR DUT_top. It accepts coefficient words over a valid/ready stream and drives the FIR's coefficient-RAM write port (update flag, address, write data). A load session starts only on a 600 kHz sample boundary, so a RAM rewrite never begins partway through a sample period. Writes are paced at one word per two clocks, and the block reports completion, abort and configuration errors.

---
 rtl/fir_coeff_loader.sv | 172 +++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// ============================================================================
// fir_coeff_loader : sample-aligned, paced coefficient-RAM loader for the FIR
// Revision 1.0
// ============================================================================
`default_nettype none

module fir_coeff_loader #(
  parameter int COEFF_W  = 16,
  parameter int ADDR_W   = 6,
  parameter int MAX_TAPS = 40
) (
  input  logic               iClk12M,
  input  logic               iRst,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [ADDR_W-1:0]  iNumOfCoeff,
  input  logic               iEnSample600k,
  input  logic               iCoeffValid,
  input  logic [COEFF_W-1:0] iCoeffData,
  output logic               oCoeffReady,
  output logic               oCoeffUpdateFlag,
  output logic [ADDR_W-1:0]  oAddrRam,
  output logic [COEFF_W-1:0] oWrDtRam,
  output logic               oWrEn,
  output logic               oBusy,
  output logic               oDone,
  output logic               oErr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    LOAD      = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_TAPS);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]    n_q, n_d;
  logic                 flush_q, flush_d;
  logic                 ready_q, ready_d;
  logic                 flag_q, flag_d;
  logic                 wren_q, wren_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COEFF_W-1:0]   data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic accept;
  logic start_ok;

  assign accept   = iCoeffValid & ready_q;
  assign start_ok = (iNumOfCoeff != '0) && (iNumOfCoeff <= MAX_N);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    flush_d = 1'b0;
    ready_d = 1'b0;
    flag_d  = flag_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // An abort kills the session outright, including a write pending from this cycle.
    if (state_q != IDLE && iAbort) begin
      state_d = IDLE;
      flag_d  = 1'b0;
      err_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          flag_d = 1'b0;
          if (iStart) begin
            if (start_ok) begin
              n_d     = iNumOfCoeff;
              cnt_d   = '0;
              err_d   = 1'b0;
              state_d = WAIT_SYNC;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WAIT_SYNC: begin
          if (iEnSample600k) begin
            state_d = LOAD;
            flag_d  = 1'b1;
            ready_d = 1'b1;
          end
        end
        LOAD: begin
          ready_d = ~accept;
          if (accept) begin
            wren_d = 1'b1;
            addr_d = cnt_q;
            data_d = iCoeffData;
            cnt_d  = cnt_q + ONE;
            if (cnt_q == n_q - ONE) begin
              state_d = FLUSH;
              ready_d = 1'b0;
            end
          end
        end
        FLUSH: begin
          // Two cycles in FLUSH keep the flag up one clock past the last write.
          if (!flush_q) begin
            flush_d = 1'b1;
          end else begin
            state_d = IDLE;
            flag_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      flush_q <= 1'b0;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      flush_q <= flush_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oCoeffReady      = ready_q;
  assign oCoeffUpdateFlag = flag_q;
  assign oAddrRam         = addr_q;
  assign oWrDtRam         = data_q;
  assign oWrEn            = wren_q;
  assign oBusy            = busy_q;
  assign oDone            = done_q;
  assign oErr             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
// ============================================================================
// tb_fir_coeff_loader : self-checking bench for fir_coeff_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        iRst = 1'b0;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic [5:0]  iNumOfCoeff = '0;
  logic        iEnSample600k = 1'b0;
  logic        iCoeffValid = 1'b0;
  logic [15:0] iCoeffData = '0;
  logic        oCoeffReady, oCoeffUpdateFlag, oWrEn, oBusy, oDone, oErr;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;

  fir_coeff_loader dut (
    .iClk12M         (clk),
    .iRst            (iRst),
    .iStart          (iStart),
    .iAbort          (iAbort),
    .iNumOfCoeff     (iNumOfCoeff),
    .iEnSample600k   (iEnSample600k),
    .iCoeffValid     (iCoeffValid),
    .iCoeffData      (iCoeffData),
    .oCoeffReady     (oCoeffReady),
    .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oAddrRam        (oAddrRam),
    .oWrDtRam        (oWrDtRam),
    .oWrEn           (oWrEn),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oErr            (oErr)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int phase  = 0;
  bit strobe_en = 1'b0;

  // Scoreboard: expected write index, last written values, session counters.
  int          sb_idx = 0;
  logic [5:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  int          wr_count = 0;
  int          done_count = 0;
  int          wr_cyc_last = 0;
  int          last_gap = 0;
  bit          last_acc = 1'b0;

  typedef struct {
    bit         start;
    bit         abort;
    logic [5:0] num;
    bit         exp_err;
    bit         exp_busy;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        acc, kill;
    logic [15:0] d;
    iEnSample600k = strobe_en && (phase == 19);
    acc  = iCoeffValid && oCoeffReady;
    kill = iAbort || iRst;
    d    = iCoeffData;
    @(posedge clk);
    #1;
    phase = (phase == 19) ? 0 : phase + 1;
    cyc++;
    last_acc = acc;
    if (iRst) begin
      sb_idx    = 0;
      last_addr = '0;
      last_data = '0;
    end
    chk("wren", 32'(oWrEn), 32'(acc && !kill));
    if (oWrEn) begin
      chk("wr_addr", 32'(oAddrRam), 32'(sb_idx));
      chk("wr_data", 32'(oWrDtRam), 32'(d));
      last_addr   = oAddrRam;
      last_data   = oWrDtRam;
      sb_idx++;
      wr_count++;
      last_gap    = cyc - wr_cyc_last;
      wr_cyc_last = cyc;
    end else begin
      chk("addr_hold", 32'(oAddrRam), 32'(last_addr));
      chk("data_hold", 32'(oWrDtRam), 32'(last_data));
    end
    if (acc || !oCoeffUpdateFlag) chk("ready_low", 32'(oCoeffReady), 32'd0);
    if (oDone) done_count++;
  endtask

  task automatic start_session(input int n);
    sb_idx     = 0;
    wr_count   = 0;
    done_count = 0;
    iStart      = 1'b1;
    iNumOfCoeff = 6'(n);
    tick();
    iStart      = 1'b0;
    iNumOfCoeff = 6'($urandom);
  endtask

  task automatic wait_flag(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (oCoeffUpdateFlag) break;
    end
    chk("flag_rise", 32'(oCoeffUpdateFlag), 32'd1);
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    bit ok;
    iCoeffValid = 1'b0;
    repeat (gap) tick();
    iCoeffValid = 1'b1;
    iCoeffData  = d;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = last_acc;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int n);
    iCoeffValid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (oDone) break;
      tick();
      n++;
    end
    chk("done_seen", 32'(oDone), 32'd1);
  endtask

  initial begin
    int w, p, n, lat;
    bit aborted;

    tbl[0] = '{1'b1, 1'b0, 6'd0,  1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 6'd5,  1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 6'd41, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 6'd63, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 6'd3,  1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 6'd0,  1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 6'd1,  1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 6'd9,  1'b1, 1'b0};

    // Reset state
    iRst = 1'b1;
    repeat (3) tick();
    iRst = 1'b0;
    chk("rst_ready", 32'(oCoeffReady), 32'd0);
    chk("rst_flag",  32'(oCoeffUpdateFlag), 32'd0);
    chk("rst_busy",  32'(oBusy), 32'd0);
    chk("rst_done",  32'(oDone), 32'd0);
    chk("rst_err",   32'(oErr), 32'd0);

    // Start/abort/illegal-count table, strobe held off so no session reaches LOAD
    strobe_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      iStart      = tbl[i].start;
      iAbort      = tbl[i].abort;
      iNumOfCoeff = tbl[i].num;
      tick();
      iStart = 1'b0;
      iAbort = 1'b0;
      chk($sformatf("tbl%0d_err", i),  32'(oErr), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_busy", i), 32'(oBusy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_flag", i), 32'(oCoeffUpdateFlag), 32'd0);
    end
    chk("tbl_no_writes", 32'(wr_count), 32'd0);

    // Legal start after errors clears oErr and completes
    strobe_en = 1'b1;
    start_session(3);
    chk("n3_err_clr", 32'(oErr), 32'd0);
    wait_flag(w);
    for (int k = 0; k < 3; k++) send(16'(k + 100), 0);
    wait_done(lat);
    chk("n3_writes", 32'(wr_count), 32'd3);
    chk("n3_err", 32'(oErr), 32'd0);
    tick();

    // Full load of 40 taps streamed continuously
    start_session(40);
    p = phase;
    chk("full_busy", 32'(oBusy), 32'd1);
    iCoeffValid = 1'b1;
    iCoeffData  = 16'd1;
    wait_flag(w);
    chk("full_sync_lat", 32'(w), 32'(20 - p));
    chk("full_no_early_wr", 32'(wr_count), 32'd0);
    for (int k = 0; k < 40; k++) begin
      send(16'(k + 1), 0);
      if (k > 0) chk("full_spacing", 32'(last_gap), 32'd2);
    end
    tick();
    chk("flush_flag",  32'(oCoeffUpdateFlag), 32'd1);
    chk("flush_ready", 32'(oCoeffReady), 32'd0);
    chk("flush_done",  32'(oDone), 32'd0);
    tick();
    chk("end_flag", 32'(oCoeffUpdateFlag), 32'd0);
    chk("end_done", 32'(oDone), 32'd1);
    chk("end_busy", 32'(oBusy), 32'd0);
    chk("end_err",  32'(oErr), 32'd0);
    iCoeffValid = 1'b0;
    tick();
    chk("done_pulse", 32'(oDone), 32'd0);
    chk("full_writes", 32'(wr_count), 32'd40);
    chk("full_done_cnt", 32'(done_count), 32'd1);

    // Start coincident with the strobe must wait for the next one
    for (int i = 0; i < 25 && phase != 19; i++) tick();
    start_session(3);
    wait_flag(w);
    chk("align_lat", 32'(w), 32'd20);
    for (int k = 0; k < 3; k++) send(16'($urandom), 0);
    wait_done(lat);
    chk("align_writes", 32'(wr_count), 32'd3);

    // Random back-pressure sessions
    for (int s = 0; s < 4; s++) begin
      n = (s == 0) ? 4 : int'($urandom_range(1, 12));
      start_session(n);
      wait_flag(w);
      for (int k = 0; k < n; k++) send(16'($urandom), int'($urandom_range(1, 5)));
      wait_done(lat);
      chk("bp_done_lat", 32'(lat), 32'd2);
      chk("bp_writes", 32'(wr_count), 32'(n));
      chk("bp_done_cnt", 32'(done_count), 32'd1);
      tick();
    end

    // Abort coincident with the 6th accept of a 10-word session
    start_session(10);
    wait_flag(w);
    for (int k = 0; k < 5; k++) send(16'(k + 500), 0);
    iCoeffValid = 1'b1;
    iCoeffData  = 16'd506;
    aborted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iAbort = oCoeffReady;
      tick();
      if (iAbort) begin
        aborted = 1'b1;
        iAbort  = 1'b0;
        break;
      end
    end
    chk("abort_hit",   32'(aborted), 32'd1);
    chk("abort_flag",  32'(oCoeffUpdateFlag), 32'd0);
    chk("abort_ready", 32'(oCoeffReady), 32'd0);
    chk("abort_busy",  32'(oBusy), 32'd0);
    chk("abort_err",   32'(oErr), 32'd1);
    iCoeffValid = 1'b0;
    repeat (25) tick();
    chk("abort_writes", 32'(wr_count), 32'd5);
    chk("abort_no_done", 32'(done_count), 32'd0);

    // Reset in the middle of LOAD, then a fresh session from address 0
    start_session(8);
    wait_flag(w);
    for (int k = 0; k < 3; k++) send(16'(k + 700), 0);
    iCoeffValid = 1'b0;
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("mrst_ready", 32'(oCoeffReady), 32'd0);
    chk("mrst_flag",  32'(oCoeffUpdateFlag), 32'd0);
    chk("mrst_addr",  32'(oAddrRam), 32'd0);
    chk("mrst_data",  32'(oWrDtRam), 32'd0);
    chk("mrst_busy",  32'(oBusy), 32'd0);
    chk("mrst_done",  32'(oDone), 32'd0);
    chk("mrst_err",   32'(oErr), 32'd0);
    start_session(2);
    wait_flag(w);
    for (int k = 0; k < 2; k++) send(16'($urandom), 0);
    wait_done(lat);
    chk("restart_writes", 32'(wr_count), 32'd2);
    chk("restart_last_addr", 32'(oAddrRam), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
